axi_read_slave_bridge: RTL and testbench
========================================

AXI_READ_SLAVE_BRIDGE -- requirements
Module: axi_read_slave_bridge

Interface
REQ-001 SHALL have parameter LOW_ADDRESS, default 32'h0000_0000, meaning the inclusive lower bound of the decoded address window.
REQ-002 SHALL have parameter HIGH_ADDRESS, default 32'h0000_0FFF, meaning the inclusive upper bound of the decoded address window.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of WAIT_DATA cycles before an SLVERR is forced; legal range >= 1.
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 SHALL have port ARESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port ARADDR, input, AXI_ADDR_SIZE bits: read address.
REQ-007 SHALL have port ARVALID, input, 1 bit: master address valid.
REQ-008 SHALL have port ARREADY, output, 1 bit: bridge accepts the address.
REQ-009 SHALL have port RDATA, output, AXI_DATA_SIZE x 8 bits: read data, byte-packed.
REQ-010 SHALL have port RRESP, output, axi_response_t: read response.
REQ-011 SHALL have port RVALID, output, 1 bit: read data valid.
REQ-012 SHALL have port RREADY, input, 1 bit: master accepts the data.
REQ-013 SHALL have port read_address_o, output, AXI_ADDR_SIZE bits: local device address.
REQ-014 SHALL have port read_request_o, output, 1 bit: single-cycle local read strobe.
REQ-015 SHALL have port read_data_i, input, AXI_DATA_SIZE x 8 bits: local device data.
REQ-016 SHALL have port read_valid_i, input, 1 bit: local data valid.
REQ-017 SHALL have port read_error_i, input, 1 bit: local device error, qualified by read_valid_i.

Function
REQ-018 SHALL implement an FSM with exactly three states: IDLE, WAIT_DATA, RESPOND.
REQ-019 SHALL drive ARREADY = 1 only while in IDLE, combinationally from state.
REQ-020 SHALL, in IDLE on ARVALID & ARREADY, register ARADDR into read_address_o.
REQ-021 SHALL, on that handshake with LOW_ADDRESS <= ARADDR <= HIGH_ADDRESS, go to WAIT_DATA, assert read_request_o for exactly the first WAIT_DATA cycle, and clear the timeout counter.
REQ-022 SHALL, on that handshake with ARADDR out of window, go directly to RESPOND with RDATA = 0 and RRESP = DECERR, never asserting read_request_o.
REQ-023 SHALL sample read_valid_i in every WAIT_DATA cycle, including the strobe cycle; on read_valid_i, latch read_data_i into RDATA, set RRESP = SLVERR if read_error_i else OKAY, and go to RESPOND.
REQ-024 SHALL increment the timeout counter once per WAIT_DATA cycle without read_valid_i; counter width is $clog2(TIMEOUT_CYCLES+1).
REQ-025 SHALL, when the counter equals TIMEOUT_CYCLES-1 and read_valid_i = 0, go to RESPOND with RDATA = 0 and RRESP = SLVERR.
REQ-026 SHALL give read_valid_i priority over timeout when both occur in the same cycle.
REQ-027 SHALL ignore read_valid_i, read_error_i and read_data_i outside WAIT_DATA.
REQ-028 SHALL drive RVALID = 1 only in RESPOND and hold RDATA/RRESP stable until RREADY.
REQ-029 SHALL, on RVALID & RREADY, return to IDLE; ARREADY rises the following cycle, so there are no back-to-back address accepts.
REQ-030 SHALL achieve a minimum latency of 2 cycles from the AR handshake edge to the RVALID rising edge (device answers in the strobe cycle).
REQ-031 SHALL keep a single outstanding transaction; no read reordering or interleaving.

Reset
REQ-032 SHALL, on ARESET = 1 (asynchronous), force state IDLE, ARREADY = 1, RVALID = 0, RDATA = 0, RRESP = OKAY, read_request_o = 0, read_address_o = 0, and counter = 0.
REQ-033 SHALL, if reset occurs mid-transaction, abandon the transaction silently; a late read_valid_i after reset SHALL be ignored.

Structure
REQ-034 SHALL take AXI_ADDR_SIZE, AXI_DATA_SIZE and axi_response_t (OKAY/EXOKAY/SLVERR/DECERR) from the shared AXI package; the FSM state enum is local to the module.
REQ-035 SHALL have an optional single sub-module, axi_read_timeout_counter, which is the counter with clear/enable and a terminal-count flag.

Verification
REQ-036 SHALL cover: ARADDR = 0x10 in window, device returns 0xDEADBEEF with read_valid_i in the strobe cycle, RREADY = 1 -> RVALID 2 cycles after handshake, RDATA = 0xDEADBEEF, RRESP = OKAY.
REQ-037 SHALL cover: ARADDR = 0x2000 (out of window) -> read_request_o never asserted, RVALID next cycle, RDATA = 0, RRESP = DECERR.
REQ-038 SHALL cover: in window, read_valid_i never asserted, TIMEOUT_CYCLES = 16 -> RVALID after 16 WAIT_DATA cycles, RRESP = SLVERR, RDATA = 0.
REQ-039 SHALL cover: read_valid_i = 1 with read_error_i = 1 on the 16th WAIT_DATA cycle -> RRESP = SLVERR, RDATA = read_data_i (data beats timeout).
REQ-040 SHALL cover: RREADY held 0 for 5 cycles -> RVALID/RDATA/RRESP stable, ARREADY = 0 throughout, and ARREADY = 1 on the cycle after acceptance.
REQ-041 SHALL cover: ARESET pulsed in WAIT_DATA, then read_valid_i = 1 -> no RVALID, ARREADY = 1, all outputs at reset values.

Source files
------------

// File: rtl/axi_read_slave_bridge_pkg.sv
// Shared AXI definitions: bus widths and the read response encoding.
package axi_read_slave_bridge_pkg;

    localparam int AXI_ADDR_SIZE = 32;
    localparam int AXI_DATA_SIZE = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_response_t;

endpackage

// File: rtl/axi_read_slave_bridge_if.sv
// AXI read-address and read-data channels, seen from the master and from the bridge.
interface axi_read_slave_bridge_if;
    import axi_read_slave_bridge_pkg::*;

    logic [AXI_ADDR_SIZE-1:0]   ARADDR;
    logic                       ARVALID;
    logic                       ARREADY;
    logic [AXI_DATA_SIZE*8-1:0] RDATA;
    axi_response_t              RRESP;
    logic                       RVALID;
    logic                       RREADY;

    modport master (
        output ARADDR, ARVALID, RREADY,
        input  ARREADY, RDATA, RRESP, RVALID
    );

    modport slave (
        input  ARADDR, ARVALID, RREADY,
        output ARREADY, RDATA, RRESP, RVALID
    );

endinterface

// File: rtl/axi_read_timeout_counter.sv
// Wait-cycle counter for the read bridge: clear has priority over enable and
// o_terminal flags the last permitted wait cycle.
module axi_read_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_terminal = (r_count == LAST);

endmodule

// File: rtl/axi_read_slave_bridge.sv
// AXI read slave that forwards one address-decoded read at a time to a local
// device, with a bounded wait for the device answer.
module axi_read_slave_bridge
    import axi_read_slave_bridge_pkg::*;
#(
    parameter logic [AXI_ADDR_SIZE-1:0] LOW_ADDRESS    = 32'h0000_0000,
    parameter logic [AXI_ADDR_SIZE-1:0] HIGH_ADDRESS   = 32'h0000_0FFF,
    parameter int                       TIMEOUT_CYCLES = 16
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    axi_read_slave_bridge_if.slave     axi,
    output logic [AXI_ADDR_SIZE-1:0]   read_address_o,
    output logic                       read_request_o,
    input  logic [AXI_DATA_SIZE*8-1:0] read_data_i,
    input  logic                       read_valid_i,
    input  logic                       read_error_i
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DATA,
        RESPOND
    } state_t;

    state_t                     r_state;
    state_t                     w_next_state;
    logic [AXI_DATA_SIZE*8-1:0] r_rdata;
    axi_response_t              r_rresp;
    logic [AXI_ADDR_SIZE-1:0]   r_read_address;
    logic                       r_read_request;

    logic w_ar_handshake;
    logic w_in_window;
    logic w_wait_enable;
    logic w_timeout;

    assign w_ar_handshake = (r_state == IDLE) && axi.ARVALID;
    // Offset compare keeps the window check free of constant comparisons when LOW_ADDRESS is 0.
    assign w_in_window    = (axi.ARADDR - LOW_ADDRESS) <= (HIGH_ADDRESS - LOW_ADDRESS);
    assign w_wait_enable  = (r_state == WAIT_DATA) && !read_valid_i;

    axi_read_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk      (ACLK),
        .i_rst      (ARESET),
        .i_clear    (w_ar_handshake),
        .i_enable   (w_wait_enable),
        .o_terminal (w_timeout)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (axi.ARVALID) begin
                    w_next_state = w_in_window ? WAIT_DATA : RESPOND;
                end
            end
            WAIT_DATA: begin
                if (read_valid_i || w_timeout) begin
                    w_next_state = RESPOND;
                end
            end
            RESPOND: begin
                if (axi.RREADY) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Response registers change only on entry to RESPOND, so they hold through back-pressure.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rdata        <= '0;
            r_rresp        <= OKAY;
            r_read_address <= '0;
            r_read_request <= 1'b0;
        end else begin
            r_read_request <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (axi.ARVALID) begin
                        r_read_address <= axi.ARADDR;
                        if (w_in_window) begin
                            r_read_request <= 1'b1;
                        end else begin
                            r_rdata <= '0;
                            r_rresp <= DECERR;
                        end
                    end
                end
                WAIT_DATA: begin
                    if (read_valid_i) begin
                        r_rdata <= read_data_i;
                        r_rresp <= read_error_i ? SLVERR : OKAY;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_rresp <= SLVERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign axi.ARREADY    = (r_state == IDLE);
    assign axi.RVALID     = (r_state == RESPOND);
    assign axi.RDATA      = r_rdata;
    assign axi.RRESP      = r_rresp;
    assign read_address_o = r_read_address;
    assign read_request_o = r_read_request;

endmodule

// File: tb/tb_axi_read_slave_bridge.sv
// Bench for axi_read_slave_bridge: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_axi_read_slave_bridge;
    import axi_read_slave_bridge_pkg::*;

    localparam int      TIMEOUT = 16;
    localparam longint  WIN_LO  = 64'h0;
    localparam longint  WIN_HI  = 64'hFFF;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] read_address_o;
    logic        read_request_o;
    logic [31:0] read_data_i;
    logic        read_valid_i;
    logic        read_error_i;

    always #5 ACLK = ~ACLK;

    axi_read_slave_bridge_if axi ();

    axi_read_slave_bridge #(
        .LOW_ADDRESS    (32'h0000_0000),
        .HIGH_ADDRESS   (32'h0000_0FFF),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .axi            (axi.slave),
        .read_address_o (read_address_o),
        .read_request_o (read_request_o),
        .read_data_i    (read_data_i),
        .read_valid_i   (read_valid_i),
        .read_error_i   (read_error_i)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // One open transaction at most; either waiting on the device or holding a response.
    bit            m_open;
    bit            m_have_resp;
    bit            m_strobe;
    int            m_waited;
    logic [31:0]   m_addr;
    logic [31:0]   m_data;
    axi_response_t m_rresp;

    function automatic bit in_window(input logic [31:0] a);
        return (longint'(a) >= WIN_LO) && (longint'(a) <= WIN_HI);
    endfunction

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_open      <= 1'b0;
            m_have_resp <= 1'b0;
            m_strobe    <= 1'b0;
            m_waited    <= 0;
            m_addr      <= '0;
            m_data      <= '0;
            m_rresp     <= OKAY;
        end else begin
            m_strobe <= 1'b0;
            if (!m_open) begin
                if (axi.ARVALID) begin
                    m_open <= 1'b1;
                    m_addr <= axi.ARADDR;
                    if (in_window(axi.ARADDR)) begin
                        m_waited <= 0;
                        m_strobe <= 1'b1;
                    end else begin
                        m_have_resp <= 1'b1;
                        m_data      <= '0;
                        m_rresp     <= DECERR;
                    end
                end
            end else if (!m_have_resp) begin
                m_waited <= m_waited + 1;
                if (read_valid_i) begin
                    m_have_resp <= 1'b1;
                    m_data      <= read_data_i;
                    m_rresp     <= read_error_i ? SLVERR : OKAY;
                end else if (m_waited + 1 == TIMEOUT) begin
                    m_have_resp <= 1'b1;
                    m_data      <= '0;
                    m_rresp     <= SLVERR;
                end
            end else if (axi.RREADY) begin
                m_open      <= 1'b0;
                m_have_resp <= 1'b0;
            end
        end
    end

    bit cmp_en = 1'b0;

    always @(negedge ACLK) begin
        if (cmp_en) begin
            check("cmp_arready", axi.ARREADY, !m_open);
            check("cmp_rvalid", axi.RVALID, m_have_resp);
            check("cmp_rdata", axi.RDATA, m_data);
            check("cmp_rresp", axi.RRESP, m_rresp);
            check("cmp_read_address", read_address_o, m_addr);
            check("cmp_read_request", read_request_o, m_strobe);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    // Called just after the handshake edge; returns edges counted from that handshake.
    task automatic wait_rvalid(input int budget, output int cycles);
        cycles = 1;
        while (!axi.RVALID && cycles < budget) begin
            tick();
            cycles++;
        end
        if (!axi.RVALID) check("rvalid_wait_bound", 1'b0, 1'b1);
    endtask

    task automatic issue(input logic [31:0] addr);
        axi.ARADDR  = addr;
        axi.ARVALID = 1'b1;
        tick();
        axi.ARVALID = 1'b0;
    endtask

    int cyc;
    int vprob;

    initial begin
        ARESET       = 1'b1;
        axi.ARADDR   = '0;
        axi.ARVALID  = 1'b0;
        axi.RREADY   = 1'b0;
        read_data_i  = '0;
        read_valid_i = 1'b0;
        read_error_i = 1'b0;
        #1 cmp_en = 1'b1;
        tick();
        check("reset_arready", axi.ARREADY, 1'b1);
        check("reset_rvalid", axi.RVALID, 1'b0);
        check("reset_rdata", axi.RDATA, 32'h0);
        check("reset_rresp", axi.RRESP, OKAY);
        check("reset_read_request", read_request_o, 1'b0);
        tick();
        ARESET = 1'b0;
        tick();

        // Device answers in the strobe cycle.
        axi.RREADY = 1'b1;
        issue(32'h10);
        check("inwin_strobe", read_request_o, 1'b1);
        check("inwin_address", read_address_o, 32'h10);
        read_valid_i = 1'b1;
        read_data_i  = 32'hDEAD_BEEF;
        read_error_i = 1'b0;
        wait_rvalid(10, cyc);
        read_valid_i = 1'b0;
        check("inwin_latency", cyc, 2);
        check("inwin_rdata", axi.RDATA, 32'hDEAD_BEEF);
        check("inwin_rresp", axi.RRESP, OKAY);
        check("model_pin_data", m_data, 32'hDEAD_BEEF);
        tick();
        check("inwin_arready_after", axi.ARREADY, 1'b1);

        // Out-of-window address is decoded away.
        issue(32'h2000);
        check("decerr_no_strobe", read_request_o, 1'b0);
        wait_rvalid(10, cyc);
        check("decerr_latency", cyc, 1);
        check("decerr_rdata", axi.RDATA, 32'h0);
        check("decerr_rresp", axi.RRESP, DECERR);
        check("model_pin_decerr", m_rresp, DECERR);
        tick();

        // Just above the window.
        issue(32'h1000);
        wait_rvalid(10, cyc);
        check("edge_above_latency", cyc, 1);
        check("edge_above_rresp", axi.RRESP, DECERR);
        tick();

        // Device never answers: timeout.
        issue(32'hFFF);
        wait_rvalid(40, cyc);
        check("timeout_wait_cycles", cyc - 1, TIMEOUT);
        check("timeout_rresp", axi.RRESP, SLVERR);
        check("timeout_rdata", axi.RDATA, 32'h0);
        tick();

        // Data with error arrives in the last wait cycle and beats the timeout.
        issue(32'h200);
        repeat (TIMEOUT - 1) tick();
        check("late_not_yet", axi.RVALID, 1'b0);
        read_valid_i = 1'b1;
        read_error_i = 1'b1;
        read_data_i  = 32'hCAFE_F00D;
        tick();
        read_valid_i = 1'b0;
        read_error_i = 1'b0;
        check("late_rvalid", axi.RVALID, 1'b1);
        check("late_rresp", axi.RRESP, SLVERR);
        check("late_rdata", axi.RDATA, 32'hCAFE_F00D);
        tick();

        // Back-pressure: response held while RREADY is low; device noise ignored.
        axi.RREADY = 1'b0;
        issue(32'h40);
        read_valid_i = 1'b1;
        read_data_i  = 32'h1234_5678;
        tick();
        for (int i = 0; i < 5; i++) begin
            read_data_i  = $urandom;
            read_error_i = 1'($urandom);
            tick();
            check("hold_rvalid", axi.RVALID, 1'b1);
            check("hold_rdata", axi.RDATA, 32'h1234_5678);
            check("hold_rresp", axi.RRESP, OKAY);
            check("hold_arready", axi.ARREADY, 1'b0);
        end
        read_valid_i = 1'b0;
        read_error_i = 1'b0;
        axi.RREADY   = 1'b1;
        tick();
        check("release_arready", axi.ARREADY, 1'b1);
        check("release_rvalid", axi.RVALID, 1'b0);

        // Reset mid-transaction, then a late device answer.
        issue(32'h20);
        ARESET = 1'b1;
        #1;
        check("midrst_arready", axi.ARREADY, 1'b1);
        check("midrst_read_address", read_address_o, 32'h0);
        read_valid_i = 1'b1;
        read_data_i  = 32'h0BAD_0BAD;
        tick();
        ARESET = 1'b0;
        repeat (3) tick();
        check("midrst_rvalid", axi.RVALID, 1'b0);
        check("midrst_arready_after", axi.ARREADY, 1'b1);
        check("midrst_rdata", axi.RDATA, 32'h0);
        check("midrst_rresp", axi.RRESP, OKAY);
        check("midrst_read_request", read_request_o, 1'b0);
        read_valid_i = 1'b0;
        tick();

        // Randomized traffic against the model.
        vprob = 40;
        for (int i = 0; i < 4000; i++) begin
            if (i % 250 == 0) vprob = ($urandom_range(0, 1) == 1) ? 40 : 4;
            axi.ARVALID = ($urandom_range(0, 99) < 50);
            case ($urandom_range(0, 5))
                0:       axi.ARADDR = 32'h0;
                1:       axi.ARADDR = 32'hFFF;
                2:       axi.ARADDR = 32'h1000;
                3:       axi.ARADDR = $urandom;
                default: axi.ARADDR = 32'($urandom_range(0, 32'hFFF));
            endcase
            axi.RREADY   = ($urandom_range(0, 99) < 60);
            read_valid_i = ($urandom_range(0, 99) < vprob);
            read_error_i = ($urandom_range(0, 99) < 30);
            read_data_i  = $urandom;
            if ($urandom_range(0, 599) == 0) begin
                ARESET = 1'b1;
                tick();
                ARESET = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
